gate_truth_sequencer: RTL and testbench

Self-test controller for the single-gate blocks (not/and/or/nand/nor/xor/xnor/buf). It sweeps every input vector into one gate under test (GUT) and waits a programmable settle time. It then compares the GUT output against an internal reference model, counts mismatches and reports pass/fail with the first failing vector. It sits between a bench or top-level self-test and one GUT instance, and it owns the GUT input drive.

---
 rtl/gate_truth_sequencer_pkg.sv | 32 +++
 rtl/gate_truth_sequencer_if.sv | 29 ++
 rtl/gate_truth_sequencer_ref.sv | 30 +++
 rtl/gate_truth_sequencer.sv | 145 ++++++++++++++
 tb/tb_gate_truth_sequencer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gate_truth_sequencer_pkg.sv
// Shared definitions for the gate truth-table sequencer: op encodings,
// FSM state encoding, counter widths and the vector-count helper.
package gate_truth_sequencer_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned CNT_W = 4;

  localparam logic [OP_W-1:0] OP_NOT  = 3'd0;
  localparam logic [OP_W-1:0] OP_BUF  = 3'd1;
  localparam logic [OP_W-1:0] OP_AND  = 3'd2;
  localparam logic [OP_W-1:0] OP_OR   = 3'd3;
  localparam logic [OP_W-1:0] OP_NAND = 3'd4;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd6;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Number of input vectors swept for an op: single-input ops use bit 0 only.
  function automatic int unsigned vec_count(input logic [OP_W-1:0] op,
                                            input int unsigned n_in);
    if (op == OP_NOT || op == OP_BUF) return 32'd2;
    return 32'd1 << n_in;
  endfunction

endpackage

// File: rtl/gate_truth_sequencer_if.sv
// Control/status bundle between a self-test master and the sequencer.
//   master: drives start, abort, op_sel; observes busy, done, pass,
//           err_count, fail_valid, fail_vec.
//   slave : the sequencer side of the same signals.
interface gate_truth_sequencer_if
  import gate_truth_sequencer_pkg::*;
#(
  parameter int unsigned N_IN = 2
);
  logic            start;
  logic            abort;
  logic [OP_W-1:0] op_sel;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic            fail_valid;
  logic [N_IN-1:0] fail_vec;

  modport master (
    output start, abort, op_sel,
    input  busy, done, pass, err_count, fail_valid, fail_vec
  );

  modport slave (
    input  start, abort, op_sel,
    output busy, done, pass, err_count, fail_valid, fail_vec
  );
endinterface

// File: rtl/gate_truth_sequencer_ref.sv
// Combinational reference model of the gate under test.
//   op  : gate type (package encodings)
//   vec : applied input vector; NOT/BUF look at bit 0 only
//   y_c : expected gate output
module gate_truth_sequencer_ref
  import gate_truth_sequencer_pkg::*;
#(
  parameter int unsigned N_IN = 2
) (
  input  logic [OP_W-1:0] op,
  input  logic [N_IN-1:0] vec,
  output logic            y_c
);

  always_comb begin
    y_c = 1'b0;
    case (op)
      OP_NOT:  y_c = ~vec[0];
      OP_BUF:  y_c = vec[0];
      OP_AND:  y_c = &vec;
      OP_OR:   y_c = |vec;
      OP_NAND: y_c = ~&vec;
      OP_NOR:  y_c = ~|vec;
      OP_XOR:  y_c = ^vec;
      OP_XNOR: y_c = ~^vec;
      default: y_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_truth_sequencer.sv
// Sweeps every input vector into one gate under test, waits SETTLE cycles,
// compares the gate output with the reference model and reports the result.
//   clk, rst_n : clock, asynchronous active-low reset
//   ctl        : control/status bundle (slave side)
//   gut_in     : registered vector driven to the gate under test
//   gut_y      : gate under test output, sampled at the CHECK exit edge
module gate_truth_sequencer
  import gate_truth_sequencer_pkg::*;
#(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gate_truth_sequencer_if.slave  ctl,
  output logic [N_IN-1:0]        gut_in,
  input  logic                   gut_y
);

  localparam int unsigned       ERR_W     = N_IN + 1;
  localparam logic [ERR_W-1:0]  ERR_MAX   = {1'b1, {N_IN{1'b0}}};
  localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE);

  state_t            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              fvalid_q, fvalid_d;
  logic [N_IN-1:0]   fvec_q, fvec_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              ref_y_c;
  logic              last_vec_c;
  logic              in_sweep_c;

  gate_truth_sequencer_ref #(.N_IN(N_IN)) u_ref (
    .op  (op_q),
    .vec (vec_q),
    .y_c (ref_y_c)
  );

  assign last_vec_c = (vec_q == N_IN'(vec_count(op_q, N_IN) - 32'd1));
  assign in_sweep_c = (state_q == ST_APPLY) || (state_q == ST_SETTLE) ||
                      (state_q == ST_CHECK);

  // Next-state and result update; abort outranks any CHECK update.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    vec_d    = vec_q;
    err_d    = err_q;
    fvalid_d = fvalid_q;
    fvec_d   = fvec_q;
    done_d   = 1'b0;
    pass_d   = pass_q;

    if (in_sweep_c && ctl.abort) begin
      state_d = ST_IDLE;
      vec_d   = '0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ctl.start) begin
            state_d  = ST_APPLY;
            op_d     = ctl.op_sel;
            vec_d    = '0;
            err_d    = '0;
            fvalid_d = 1'b0;
            fvec_d   = '0;
            pass_d   = 1'b0;
          end
        end
        ST_APPLY: begin
          cnt_d   = SETTLE_LD;
          state_d = (SETTLE_LD == '0) ? ST_CHECK : ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_q <= CNT_W'(1)) state_d = ST_CHECK;
          else                    cnt_d   = cnt_q - CNT_W'(1);
        end
        ST_CHECK: begin
          if (gut_y != ref_y_c) begin
            if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
            if (!fvalid_q) begin
              fvalid_d = 1'b1;
              fvec_d   = vec_q;
            end
          end
          if (last_vec_c) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            state_d = ST_APPLY;
            vec_d   = vec_q + N_IN'(1);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NOT;
      cnt_q    <= '0;
      vec_q    <= '0;
      err_q    <= '0;
      fvalid_q <= 1'b0;
      fvec_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      vec_q    <= vec_d;
      err_q    <= err_d;
      fvalid_q <= fvalid_d;
      fvec_q   <= fvec_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign gut_in         = vec_q;
  assign ctl.busy       = busy_q;
  assign ctl.done       = done_q;
  assign ctl.pass       = pass_q;
  assign ctl.err_count  = err_q;
  assign ctl.fail_valid = fvalid_q;
  assign ctl.fail_vec   = fvec_q;

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Self-checking bench: two sequencers (SETTLE=2 and SETTLE=0, N_IN=2), each
// driving a configurable model gate (correct, wired as another op, stuck at 0,
// or with per-vector output flips).
module tb_gate_truth_sequencer;
  import gate_truth_sequencer_pkg::*;

  localparam int unsigned N = 2;
  localparam int unsigned SETTLE0 = 2;
  localparam int unsigned SETTLE1 = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gate_truth_sequencer_if #(.N_IN(N)) if0 ();
  gate_truth_sequencer_if #(.N_IN(N)) if1 ();

  logic [N-1:0] gin0, gin1;
  logic         gy0, gy1;

  gate_truth_sequencer #(.N_IN(N), .SETTLE(SETTLE0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ctl(if0), .gut_in(gin0), .gut_y(gy0));
  gate_truth_sequencer #(.N_IN(N), .SETTLE(SETTLE1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ctl(if1), .gut_in(gin1), .gut_y(gy1));

  // Bench-side drive and observation, indexed by DUT number.
  logic         start_d [2];
  logic         abort_d [2];
  logic [2:0]   op_d    [2];
  logic [2:0]   gop     [2];
  logic         stuck   [2];
  logic [15:0]  fmask   [2];
  logic         busy_o  [2];
  logic         done_o  [2];
  logic         pass_o  [2];
  logic         fval_o  [2];
  logic [N:0]   err_o   [2];
  logic [N-1:0] fvec_o  [2];
  logic [N-1:0] gin_o   [2];

  assign if0.start = start_d[0];
  assign if0.abort = abort_d[0];
  assign if0.op_sel = op_d[0];
  assign if1.start = start_d[1];
  assign if1.abort = abort_d[1];
  assign if1.op_sel = op_d[1];
  assign busy_o[0] = if0.busy;
  assign busy_o[1] = if1.busy;
  assign done_o[0] = if0.done;
  assign done_o[1] = if1.done;
  assign pass_o[0] = if0.pass;
  assign pass_o[1] = if1.pass;
  assign fval_o[0] = if0.fail_valid;
  assign fval_o[1] = if1.fail_valid;
  assign err_o[0]  = if0.err_count;
  assign err_o[1]  = if1.err_count;
  assign fvec_o[0] = if0.fail_vec;
  assign fvec_o[1] = if1.fail_vec;
  assign gin_o[0]  = gin0;
  assign gin_o[1]  = gin1;

  // Truth of each gate expressed through the number of ones in the vector.
  function automatic logic gate_truth(input logic [2:0] op, input logic [N-1:0] v);
    int unsigned ones;
    ones = unsigned'($countones(v));
    case (op)
      3'd0:    return !v[0];
      3'd1:    return v[0];
      3'd2:    return ones == N;
      3'd3:    return ones != 0;
      3'd4:    return ones != N;
      3'd5:    return ones == 0;
      3'd6:    return ones[0];
      default: return !ones[0];
    endcase
  endfunction

  always_comb begin
    gy0 = stuck[0] ? 1'b0 : (gate_truth(gop[0], gin0) ^ fmask[0][gin0]);
    gy1 = stuck[1] ? 1'b0 : (gate_truth(gop[1], gin1) ^ fmask[1][gin1]);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int unsigned settle_of(input int d);
    return (d == 0) ? SETTLE0 : SETTLE1;
  endfunction

  // One full sweep on DUT d; expectations supplied by the caller.
  task automatic run_sweep(input int d, input logic [2:0] op,
                           input int unsigned exp_err, input int unsigned exp_fv,
                           input int unsigned exp_fvalid, input int unsigned exp_pass,
                           input int unsigned exp_cyc);
    int unsigned cyc;
    bit seen;
    bit hi_bad;
    @(negedge clk);
    start_d[d] = 1'b1;
    op_d[d]    = op;
    @(posedge clk); #1;
    start_d[d] = 1'b0;
    op_d[d]    = 3'($urandom_range(7));
    chk("start_busy", 32'(busy_o[d]), 32'd1);
    chk("start_err_clr", 32'(err_o[d]), 32'd0);
    chk("start_fval_clr", 32'(fval_o[d]), 32'd0);
    chk("start_pass_clr", 32'(pass_o[d]), 32'd0);
    chk("start_gin", 32'(gin_o[d]), 32'd0);
    seen = 1'b0; cyc = 0; hi_bad = 1'b0;
    for (int i = 1; i <= 200 && !seen; i++) begin
      @(posedge clk); #1;
      if (op < 3'd2 && gin_o[d][N-1:1] != '0) hi_bad = 1'b1;
      if (done_o[d]) begin
        seen = 1'b1;
        cyc  = i;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("done_cycle", cyc, exp_cyc);
    chk("gin_upper_zero", 32'(hi_bad), 32'd0);
    chk("err_count", 32'(err_o[d]), exp_err);
    chk("fail_valid", 32'(fval_o[d]), exp_fvalid);
    chk("fail_vec", 32'(fvec_o[d]), exp_fv);
    chk("pass", 32'(pass_o[d]), exp_pass);
    chk("busy_in_done", 32'(busy_o[d]), 32'd1);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done_o[d]), 32'd0);
    chk("busy_after_done", 32'(busy_o[d]), 32'd0);
    chk("pass_sticky", 32'(pass_o[d]), exp_pass);
  endtask

  typedef struct {
    int          d;
    logic [2:0]  op;
    logic [2:0]  gut_op;
    logic        gut_stuck;
    int unsigned err;
    int unsigned fv;
    int unsigned fvalid;
    int unsigned pass;
    int unsigned cyc;
  } row_t;

  row_t tbl [9];

  initial begin
    bit seen;
    for (int d = 0; d < 2; d++) begin
      start_d[d] = 1'b0; abort_d[d] = 1'b0; op_d[d] = 3'd0;
      gop[d] = 3'd0; stuck[d] = 1'b0; fmask[d] = '0;
    end

    //           d  op       gut op   stuck err fv fval pass cyc
    tbl[0] = '{0, OP_NOT,  OP_NOT,  1'b0, 0, 0, 0, 1,  8};
    tbl[1] = '{0, OP_AND,  OP_OR,   1'b0, 2, 1, 1, 0, 16};
    tbl[2] = '{0, OP_NAND, OP_NAND, 1'b1, 3, 0, 1, 0, 16};
    tbl[3] = '{1, OP_XNOR, OP_XNOR, 1'b1, 2, 0, 1, 0,  8};
    tbl[4] = '{1, OP_XOR,  OP_XOR,  1'b0, 0, 0, 0, 1,  8};
    tbl[5] = '{1, OP_XOR,  OP_XOR,  1'b0, 0, 0, 0, 1,  8};
    tbl[6] = '{1, OP_BUF,  OP_BUF,  1'b1, 1, 1, 1, 0,  4};
    tbl[7] = '{0, OP_XNOR, OP_XOR,  1'b0, 4, 0, 1, 0, 16};
    tbl[8] = '{0, OP_NOR,  OP_NOR,  1'b0, 0, 0, 0, 1, 16};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", 32'(busy_o[d]), 32'd0);
      chk("rst_done", 32'(done_o[d]), 32'd0);
      chk("rst_pass", 32'(pass_o[d]), 32'd0);
      chk("rst_err", 32'(err_o[d]), 32'd0);
      chk("rst_fval", 32'(fval_o[d]), 32'd0);
      chk("rst_fvec", 32'(fvec_o[d]), 32'd0);
      chk("rst_gin", 32'(gin_o[d]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 9; r++) begin
      gop[tbl[r].d]   = tbl[r].gut_op;
      stuck[tbl[r].d] = tbl[r].gut_stuck;
      fmask[tbl[r].d] = '0;
      run_sweep(tbl[r].d, tbl[r].op, tbl[r].err, tbl[r].fv, tbl[r].fvalid,
                tbl[r].pass, tbl[r].cyc);
    end

    // Abort during SETTLE of vector 2; a start pulse while busy is ignored.
    gop[0] = OP_OR; stuck[0] = 1'b0; fmask[0] = '0;
    @(negedge clk);
    start_d[0] = 1'b1; op_d[0] = OP_AND;
    @(posedge clk); #1;
    start_d[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start_d[0] = 1'b1;
    @(posedge clk); #1;
    start_d[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_pre_gin", 32'(gin_o[0]), 32'd2);
    chk("abort_pre_err", 32'(err_o[0]), 32'd1);
    chk("abort_pre_busy", 32'(busy_o[0]), 32'd1);
    abort_d[0] = 1'b1;
    @(posedge clk); #1;
    abort_d[0] = 1'b0;
    chk("abort_busy", 32'(busy_o[0]), 32'd0);
    chk("abort_gin", 32'(gin_o[0]), 32'd0);
    chk("abort_pass", 32'(pass_o[0]), 32'd0);
    chk("abort_err_hold", 32'(err_o[0]), 32'd1);
    chk("abort_fval_hold", 32'(fval_o[0]), 32'd1);
    chk("abort_fvec_hold", 32'(fvec_o[0]), 32'd1);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done_o[0] || busy_o[0]) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);

    // Start and abort together in IDLE: start wins.
    @(negedge clk);
    start_d[0] = 1'b1; abort_d[0] = 1'b1; op_d[0] = OP_OR;
    @(posedge clk); #1;
    start_d[0] = 1'b0; abort_d[0] = 1'b0;
    chk("start_beats_abort", 32'(busy_o[0]), 32'd1);
    abort_d[0] = 1'b1;
    @(posedge clk); #1;
    abort_d[0] = 1'b0;
    chk("abort_from_apply", 32'(busy_o[0]), 32'd0);

    // Asynchronous reset during CHECK of vector 1, then a fresh sweep.
    gop[0] = OP_NAND; stuck[0] = 1'b1;
    @(negedge clk);
    start_d[0] = 1'b1; op_d[0] = OP_NAND;
    @(posedge clk); #1;
    start_d[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("prereset_err", 32'(err_o[0]), 32'd1);
    chk("prereset_gin", 32'(gin_o[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_busy", 32'(busy_o[0]), 32'd0);
    chk("async_err", 32'(err_o[0]), 32'd0);
    chk("async_fval", 32'(fval_o[0]), 32'd0);
    chk("async_fvec", 32'(fvec_o[0]), 32'd0);
    chk("async_gin", 32'(gin_o[0]), 32'd0);
    chk("async_pass", 32'(pass_o[0]), 32'd0);
    chk("async_done", 32'(done_o[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(0, OP_NAND, 3, 0, 1, 0, 16);

    // Random ops and random per-vector faults against the truth-table model.
    for (int t = 0; t < 20; t++) begin
      int          d;
      logic [2:0]  op;
      int unsigned nv;
      int unsigned e_err;
      int unsigned e_fv;
      logic [15:0] mask;
      d    = int'($urandom_range(1));
      op   = 3'($urandom_range(7));
      nv   = (op < 3'd2) ? 2 : (1 << N);
      mask = 16'($urandom) & 16'((1 << nv) - 1);
      if (t % 5 == 0) mask = '0;
      gop[d] = op; stuck[d] = 1'b0; fmask[d] = mask;
      e_err = unsigned'($countones(mask));
      e_fv  = 0;
      for (int k = int'(nv) - 1; k >= 0; k--) if (mask[k]) e_fv = unsigned'(k);
      run_sweep(d, op, e_err, e_fv, (mask != '0) ? 1 : 0, (mask == '0) ? 1 : 0,
                nv * (settle_of(d) + 2));
      fmask[d] = '0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
